// File: rtl/decode_stage_pipe.sv
// Decode stage between fetch and register-read: splits an RV32/RV64 instruction into fields,
// immediate and register-use flags behind a 2-entry skid buffer. Optional macro: DECODE_ILLEGAL_CHECK_EN.
module decode_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [2:0]        out_fmt,
  output logic              out_rd_we,
  output logic              out_rs1_used,
  output logic              out_rs2_used,
  output logic              out_illegal
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   imm;
    logic [2:0]        fmt;
    logic              rd_we;
    logic              rs1_used;
    logic              rs2_used;
    logic              illegal;
  } bundle_t;

  function automatic logic [2:0] fmt_of(input logic [6:0] opc);
    case (opc)
      7'b0110011:                                              return FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: return FMT_I;
      7'b0100011:                                              return FMT_S;
      7'b1100011:                                              return FMT_B;
      7'b0110111, 7'b0010111:                                  return FMT_U;
      7'b1101111:                                              return FMT_J;
      default:                                                 return FMT_NONE;
    endcase
  endfunction

  // Build the 32-bit signed immediate, then let the sized cast sign-extend it to XLEN.
  function automatic logic [XLEN-1:0] imm_of(input logic [31:0] ins, input logic [2:0] fmt);
    logic signed [31:0] imm32;
    case (fmt)
      FMT_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm32 = {ins[31:12], 12'b0};
      FMT_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    return XLEN'(imm32);
  endfunction

`ifdef DECODE_ILLEGAL_CHECK_EN
  function automatic logic illegal_of(input logic [31:0] ins, input logic [2:0] fmt);
    logic       bad;
    logic [2:0] f3;
    logic [6:0] f7;
    f3  = ins[14:12];
    f7  = ins[31:25];
    bad = (ins[1:0] != 2'b11) || (fmt == FMT_NONE);
    if (ins[6:0] == OP_REG) begin
      if (f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
      if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101) bad = 1'b1;
    end
    if (ins[6:0] == OP_IMM) begin
      if (f3 == 3'b001 && f7 != 7'h00) bad = 1'b1;
      if (XLEN == 32 && f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  bundle_t dec;
  logic    legal;

  always_comb begin
    dec        = '0;
    legal      = 1'b1;
    dec.pc     = in_pc;
    dec.opcode = in_instr[6:0];
    dec.funct3 = in_instr[14:12];
    dec.funct7 = in_instr[31:25];
    dec.fmt    = fmt_of(in_instr[6:0]);
    dec.imm    = imm_of(in_instr, dec.fmt);
`ifdef DECODE_ILLEGAL_CHECK_EN
    dec.illegal = illegal_of(in_instr, dec.fmt);
    legal       = !dec.illegal;
`endif
    dec.rs1_used = legal && (dec.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B});
    dec.rs2_used = legal && (dec.fmt inside {FMT_R, FMT_S, FMT_B});
    dec.rd_we    = legal && (dec.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (in_instr[11:7] != 5'd0);
    dec.rs1      = dec.rs1_used ? in_instr[15 +: REG_AW] : '0;
    dec.rs2      = dec.rs2_used ? in_instr[20 +: REG_AW] : '0;
    dec.rd       = dec.rd_we    ? in_instr[7 +: REG_AW]  : '0;
  end

  // ---- skid buffer: main drives the outputs, skid only fills while main is stalled ----
  bundle_t main_q, main_d, skid_q, skid_d;
  logic    main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic    accept, drain;

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready && !flush;
  assign drain    = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      // skid being full implies in_ready=0, so no new accept can race with the refill
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_pc       = main_q.pc;
  assign out_opcode   = main_q.opcode;
  assign out_funct3   = main_q.funct3;
  assign out_funct7   = main_q.funct7;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_rd       = main_q.rd;
  assign out_imm      = main_q.imm;
  assign out_fmt      = main_q.fmt;
  assign out_rd_we    = main_q.rd_we;
  assign out_rs1_used = main_q.rs1_used;
  assign out_rs2_used = main_q.rs2_used;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: XLEN=32 and XLEN=64 instances share stimulus and are checked
// against a queue-based reference model of the held instructions.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  always #5 clk = ~clk;

  logic        a_in_ready, a_out_valid, a_rd_we, a_u1, a_u2, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [6:0]  a_opc, a_f7;
  logic [2:0]  a_f3, a_fmt;
  logic [4:0]  a_rs1, a_rs2, a_rd;

  logic        b_in_ready, b_out_valid, b_rd_we, b_u1, b_u2, b_ill;
  logic [63:0] b_pc, b_imm;
  logic [6:0]  b_opc, b_f7;
  logic [2:0]  b_f3, b_fmt;
  logic [4:0]  b_rs1, b_rs2, b_rd;

  decode_stage_pipe #(.XLEN(32), .REG_AW(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_opcode(a_opc), .out_funct3(a_f3), .out_funct7(a_f7),
    .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm), .out_fmt(a_fmt),
    .out_rd_we(a_rd_we), .out_rs1_used(a_u1), .out_rs2_used(a_u2), .out_illegal(a_ill));

  decode_stage_pipe #(.XLEN(64), .REG_AW(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_opcode(b_opc), .out_funct3(b_f3), .out_funct7(b_f7),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm), .out_fmt(b_fmt),
    .out_rd_we(b_rd_we), .out_rs1_used(b_u1), .out_rs2_used(b_u2), .out_illegal(b_ill));

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } item_t;

  item_t q[$];
  int    vectors = 0;
  int    miscompares = 0;

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] r_fmt(input logic [31:0] i);
    case (i[6:0])
      7'h33:                             return 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: return 3'd1;
      7'h23:                             return 3'd2;
      7'h63:                             return 3'd3;
      7'h37, 7'h17:                      return 3'd4;
      7'h6F:                             return 3'd5;
      default:                           return 3'd7;
    endcase
  endfunction

  // Immediate value as a plain signed number: weighted field sum minus the sign weight.
  function automatic longint r_imm(input logic [31:0] i);
    longint v;
    case (r_fmt(i))
      3'd1: begin v = longint'(i[31:20]); if (i[31]) v -= 4096; end
      3'd2: begin v = longint'(i[31:25]) * 32 + longint'(i[11:7]); if (i[31]) v -= 4096; end
      3'd3: begin
        v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (i[31]) v -= 4096;
      end
      3'd4: begin v = longint'(i[31:12]) * 4096; if (i[31]) v -= 64'sh1_0000_0000; end
      3'd5: begin
        v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (i[31]) v -= 64'sh10_0000;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic r_illegal(input logic [31:0] i, input logic is64);
    logic       bad;
    logic [6:0] f7;
    logic [2:0] f3;
    f7  = i[31:25];
    f3  = i[14:12];
    bad = (i[1:0] != 2'b11) || (r_fmt(i) == 3'd7);
    if (i[6:0] == 7'h33 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) bad = 1'b1;
    if (i[6:0] == 7'h13 && f3 == 3'd1 && f7 != 7'h00) bad = 1'b1;
    if (i[6:0] == 7'h13 && f3 == 3'd5 && !is64 && f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
    return CHECK_EN && bad;
  endfunction

  task automatic chk_bundle(input string p, input logic is64, input item_t it,
                            input logic [63:0] pc, input logic [6:0] opc, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [63:0] imm, input logic [2:0] fmt,
                            input logic we, input logic u1, input logic u2, input logic ill);
    logic [2:0]  ef;
    logic        eill, eu1, eu2, ewe;
    longint      v;
    logic [63:0] eimm, epc;
    ef   = r_fmt(it.instr);
    eill = r_illegal(it.instr, is64);
    eu1  = !eill && (ef inside {3'd0, 3'd1, 3'd2, 3'd3});
    eu2  = !eill && (ef inside {3'd0, 3'd2, 3'd3});
    ewe  = !eill && (ef inside {3'd0, 3'd1, 3'd4, 3'd5}) && (it.instr[11:7] != 5'd0);
    v    = r_imm(it.instr);
    eimm = is64 ? 64'(v) : {32'd0, v[31:0]};
    epc  = is64 ? it.pc : {32'd0, it.pc[31:0]};
    chk({p, ".pc"}, pc, epc);
    chk({p, ".opcode"}, 64'(opc), 64'(it.instr[6:0]));
    chk({p, ".funct3"}, 64'(f3), 64'(it.instr[14:12]));
    chk({p, ".funct7"}, 64'(f7), 64'(it.instr[31:25]));
    chk({p, ".rs1"}, 64'(rs1), eu1 ? 64'(it.instr[19:15]) : 64'd0);
    chk({p, ".rs2"}, 64'(rs2), eu2 ? 64'(it.instr[24:20]) : 64'd0);
    chk({p, ".rd"}, 64'(rd), ewe ? 64'(it.instr[11:7]) : 64'd0);
    chk({p, ".imm"}, imm, eimm);
    chk({p, ".fmt"}, 64'(fmt), 64'(ef));
    chk({p, ".rd_we"}, 64'(we), 64'(ewe));
    chk({p, ".rs1_used"}, 64'(u1), 64'(eu1));
    chk({p, ".rs2_used"}, 64'(u2), 64'(eu2));
    chk({p, ".illegal"}, 64'(ill), 64'(eill));
  endtask

  task automatic check_all();
    logic exp_v, exp_rdy;
    exp_v   = q.size() > 0;
    exp_rdy = q.size() < 2;
    chk("a.out_valid", 64'(a_out_valid), 64'(exp_v));
    chk("b.out_valid", 64'(b_out_valid), 64'(exp_v));
    chk("a.in_ready", 64'(a_in_ready), 64'(exp_rdy));
    chk("b.in_ready", 64'(b_in_ready), 64'(exp_rdy));
    if (exp_v) begin
      chk_bundle("a", 1'b0, q[0], {32'd0, a_pc}, a_opc, a_f3, a_f7, a_rs1, a_rs2, a_rd,
                 {32'd0, a_imm}, a_fmt, a_rd_we, a_u1, a_u2, a_ill);
      chk_bundle("b", 1'b1, q[0], b_pc, b_opc, b_f3, b_f7, b_rs1, b_rs2, b_rd,
                 b_imm, b_fmt, b_rd_we, b_u1, b_u2, b_ill);
    end
  endtask

  // Drive one cycle from a negedge, advance the model across the posedge, check at the next negedge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    item_t it;
    logic  acc;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = {$urandom(), $urandom()};
    out_ready = ordy;
    flush     = fl;
    it.instr  = ins;
    it.pc     = in_pc;
    if (fl) q.delete();
    else begin
      acc = v && (q.size() < 2);
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back(it);
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    logic [31:0] i;
    int          k;
    i = $urandom();
    k = $urandom_range(0, 11);
    if (k < 11) i[6:0] = ops[k];
    if ($urandom_range(0, 1) == 1) i[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 7) == 0) i[11:7] = 5'd0;
    return i;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all();
    chk("rst.a_imm", {32'd0, a_imm}, 64'd0);
    chk("rst.b_pc", b_pc, 64'd0);
    chk("rst.a_fmt", 64'(a_fmt), 64'd0);
    chk("rst.a_rd_we", 64'(a_rd_we), 64'd0);

    cycle(1'b1, 32'h00500093, 1'b1, 1'b0);
    chk("addi.fmt", 64'(a_fmt), 64'd1);
    chk("addi.rd", 64'(a_rd), 64'd1);
    chk("addi.rs1", 64'(a_rs1), 64'd0);
    chk("addi.imm", {32'd0, a_imm}, 64'd5);
    chk("addi.rd_we", 64'(a_rd_we), 64'd1);
    chk("addi.rs2_used", 64'(a_u2), 64'd0);

    cycle(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
    chk("beq.fmt", 64'(a_fmt), 64'd3);
    chk("beq.imm", {32'd0, a_imm}, 64'h0000_0000_FFFF_FFFC);
    chk("beq.rs1_used", 64'(a_u1), 64'd1);
    chk("beq.rs2_used", 64'(a_u2), 64'd1);
    chk("beq.rd_we", 64'(a_rd_we), 64'd0);
    chk("beq.rd", 64'(a_rd), 64'd0);

    cycle(1'b1, 32'h800002B7, 1'b1, 1'b0);
    chk("lui64.imm", b_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui64.rd", 64'(b_rd), 64'd5);
    chk("lui32.imm", {32'd0, a_imm}, 64'h0000_0000_8000_0000);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // back-pressure: two accepts fill main+skid, then in_ready falls
    cycle(1'b1, 32'h00100113, 1'b0, 1'b0);
    cycle(1'b1, 32'h00208193, 1'b0, 1'b0);
    chk("bp.in_ready", 64'(a_in_ready), 64'd0);
    cycle(1'b1, 32'h00310233, 1'b0, 1'b0);
    cycle(1'b1, 32'h00310233, 1'b1, 1'b0);
    cycle(1'b1, 32'h00310233, 1'b1, 1'b0);
    cycle(1'b1, 32'h004182B3, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp.drained", 64'(a_out_valid), 64'd0);

    // flush with both entries held and an incoming instruction
    cycle(1'b1, 32'h00A00313, 1'b0, 1'b0);
    cycle(1'b1, 32'h00B00393, 1'b0, 1'b0);
    cycle(1'b1, 32'h00C00413, 1'b0, 1'b1);
    chk("flush.out_valid", 64'(a_out_valid), 64'd0);
    chk("flush.in_ready", 64'(a_in_ready), 64'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // asynchronous reset while full: contents vanish without waiting for a clock
    cycle(1'b1, 32'h00D00493, 1'b0, 1'b0);
    cycle(1'b1, 32'h00E00513, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst.out_valid", 64'(a_out_valid), 64'd0);
    chk("arst.in_ready", 64'(b_in_ready), 64'd1);
    chk("arst.imm", b_imm, 64'd0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_all();

    cycle(1'b1, 32'h0000007F, 1'b1, 1'b0);
    chk("none.fmt", 64'(a_fmt), 64'd7);
    chk("none.illegal", 64'(a_ill), 64'(CHECK_EN));
    chk("none.flags", {61'd0, a_rd_we, a_u1, a_u2}, 64'd0);

    for (int n = 0; n < 500; n++) begin
      cycle($urandom_range(0, 3) != 0, gen_instr(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0);
    end
    for (int n = 0; n < 3; n++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised successor to the current decoder.
- Sits between fetch and register-read in the multi-cycle pipelined RISC-V core.
- Accepts one 32-bit instruction plus PC per handshake and splits it into fields.
- Generates the sign-extended immediate for all base formats (R/I/S/B/U/J) and register-use flags, then presents them registered to the next stage over a valid/ready interface.
- A 2-entry skid buffer decouples back-pressure so that full throughput (1 instr/cycle) is sustained.

Parameters:
- XLEN, 32, datapath width of out_imm and PC; legal values 32 or 64.
- REG_AW, 5, register-index width; fixed at 5 for RV32I/RV64I and kept parametric for RV32E (4).

Ports:
- clk  in  1  single core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held and incoming instructions
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- out_pc  out  XLEN  PC carried through
- out_opcode  out  7  instr[6:0]
- out_funct3  out  3  instr[14:12]
- out_funct7  out  7  instr[31:25]
- out_rs1  out  REG_AW  instr[19:15]; 0 if unused
- out_rs2  out  REG_AW  instr[24:20]; 0 if unused
- out_rd  out  REG_AW  instr[11:7]; 0 if out_rd_we=0
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5, NONE=7
- out_rd_we  out  1  instruction writes a non-zero rd
- out_rs1_used  out  1  rs1 read required
- out_rs2_used  out  1  rs2 read required
- out_illegal  out  1  illegal-instruction flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1): every out_* register, main_valid and skid_valid are cleared to 0; in_ready=1 from the first cycle after reset.
- Handshake: a transfer occurs when valid & ready on the same edge. Latency is 1 cycle: an instruction accepted at edge N appears on out_* after edge N.
- Skid buffer: main register drives out_*.
  - in_ready = !skid_valid, registered; not combinational from out_ready.
  - Accept while main is full and not draining: the bundle goes to skid.
  - When main drains: skid moves to main; otherwise a new accept moves to main.
  - Ordering is strictly preserved.
  - Simultaneous accept and drain with skid empty: the new bundle replaces main, and out_valid stays 1.
- Decode (combinational on input, captured into main/skid), by opcode:
  - 0110011: R
  - 0010011, 0000011, 1100111, 1110011, 0001111: I
  - 0100011: S
  - 1100011: B
  - 0110111, 0010111: U
  - 1101111: J
  - anything else: NONE
- Immediates, each sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
  - U: {instr[31:12], 12'b0}; with XLEN=64, bits 63:32 are copies of bit 31
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
  - R and NONE: 0
- Register-use flags:
  - rs1_used: R, I, S, B
  - rs2_used: R, S, B
  - rd_we: (R, I, U, J) and instr[11:7]!=0
- Flush: at the edge where flush=1, main_valid and skid_valid clear; any same-cycle input handshake is discarded. out_valid=0 the next cycle, and in_ready=1 the next cycle.
- flush has priority over out_ready and in_valid.
- Reset mid-operation: held bundles are lost immediately; there is no drain.
- Payload registers update only on load; they hold their value while out_valid=0.

Optional Feature:
- Macro: DECODE_ILLEGAL_CHECK_EN
- Defined: out_illegal=1 (registered with the bundle) when any of the following holds:
  - instr[1:0]!=2'b11;
  - fmt=NONE;
  - R-type funct7 is not 0000000 or 0100000, or funct7=0100000 with funct3 not 000/101;
  - OP-IMM funct3=001 with funct7!=0;
  - OP-IMM funct3=101 with funct7 not 0000000/0100000 (XLEN=32 only).
  An illegal bundle forces rd_we, rs1_used and rs2_used to 0. It still flows through the handshake normally.
- Undefined: out_illegal tied to 0, no check logic is built, and NONE-format words decode with all use flags 0.

Test Plan:
- Reset then in_instr=0x00500093 (addi x1,x0,5), out_ready=1 → next cycle out_valid=1, out_fmt=1, out_rd=1, out_rs1=0, out_imm=5, out_rd_we=1, out_rs2_used=0.
- Branch 0xFE000EE3 (beq x0,x0,-4) → out_fmt=3, out_imm=0xFFFFFFFC, out_rs1_used=1, out_rs2_used=1, out_rd_we=0, out_rd=0.
- XLEN=64, lui 0x800002B7 → out_imm=0xFFFFFFFF80000000, out_rd=5.
- Back-to-back stream of 4 instructions with out_ready held 0 for 3 cycles → in_ready drops after 2 accepts, no loss or duplication, order preserved once out_ready=1.
- flush asserted while both main and skid are full and in_valid=1 → next cycle out_valid=0, in_ready=1, the flushed instructions never appear.
- With DECODE_ILLEGAL_CHECK_EN: 0x0000007F → out_illegal=1, out_fmt=7, all use flags 0. Without the macro, the same input gives out_illegal=0.
